rv32_wb_sram: RTL and testbench
===============================

Name: rv32_wb_sram

Overview:
- Wishbone B4 registered-feedback responder backing a word-addressed on-chip RAM.
- Faces the rv32_cpu ibus or dbus initiator; one instance per bus in simulation, formal and FPGA tops.
- Supports classic cycles and incrementing bursts (linear and 4/8/16-beat wrap) with zero-wait-state beats after the first.
- Flags accesses outside its window with err.

Parameters:
- DEPTH_WORDS, 1024, RAM size in 32-bit words; power of two, 16 to 65536.
- BASE_WORD, 0, word address of RAM word 0 on the 30-bit bus.
- INIT_FILE, "", hex image loaded with readmemh at elaboration; empty means no load.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- bus__adr  input  30  word address
- bus__dat_w  input  32  write data
- bus__dat_r  output  32  read data, valid while bus__ack is high
- bus__sel  input  4  byte enables; bit n selects byte n (little-endian)
- bus__cyc  input  1  cycle valid
- bus__stb  input  1  strobe
- bus__ack  output  1  transfer acknowledge
- bus__we  input  1  write enable
- bus__cti  input  3  cycle type: 000 classic, 001 constant, 010 incrementing, 111 end-of-burst
- bus__bte  input  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
- bus__err  output  1  error acknowledge

Behaviour:
- Reset: bus__ack=0, bus__err=0, bus__dat_r=0, state IDLE, forced asynchronously. RAM contents are not reset. Reset mid-burst aborts the burst; no write occurs on an edge where rst is high.
- req = cyc & stb; hit = BASE_WORD <= adr < BASE_WORD+DEPTH_WORDS; index = adr - BASE_WORD, truncated to log2(DEPTH_WORDS) bits.
- State IDLE:
  - On req & !hit: err=1 next cycle for exactly one cycle, then IDLE. No write; dat_r=0.
  - On req & hit & cti in {000, 001, 111}: go to CLASSIC. ack=1 next cycle for one cycle. dat_r = RAM[index] as sampled at the request edge.
  - On req & hit & cti=010: go to BURST. ack=1 next cycle.
- State CLASSIC: ack drops the following cycle, returning to IDLE. Back-to-back classic requests therefore complete every 2 cycles.
- State BURST:
  - ack stays high every cycle while req, cti=010 and adr equals the predicted address.
  - Predicted next = adr+1 within the bte wrap boundary. Low 2/3/4 bits wrap for wrap4/wrap8/wrap16; upper bits are held. Linear is a plain +1.
  - dat_r for each beat is read from the predicted address on the previous edge.
  - cti=111 with ack: final beat; ack=0 next cycle, go to IDLE.
  - Address mismatch, stb=0, or cti change to 000/001: ack=0 next cycle, go to IDLE. The request is then re-evaluated as new from IDLE.
  - Predicted address leaving the window (linear burst only): ack=0 on that beat, IDLE, then err on re-request.
- Writes:
  - Committed at the rising edge where cyc & stb & we & ack are all high.
  - Only bytes with sel=1 are written.
  - sel=0000 still acks, with no change to RAM.
  - Reads ignore sel and always return 32 bits.
- cyc low in any state: ack/err forced to 0 next cycle, state IDLE, no write.
- ack and err are never high together and never high while cyc was low on the previous edge.
- Read-during-write to the same index in a burst returns the new data on the following beat. No stale forwarding is required within a beat.

Decomposition:
- Package rv32_wb_pkg holds:
  - CTI_CLASSIC, CTI_CONST, CTI_INCR, CTI_EOB constants.
  - BTE_LINEAR, BTE_WRAP4, BTE_WRAP8, BTE_WRAP16 constants.
  - The wb_state_t enum {IDLE, CLASSIC, BURST}.
  - A function for the byte-lane write mask.
- One sub-module, rv32_wb_burst_addr: combinational next-address from adr and bte. It is shared with the planned cache refill master.

Test Plan:
- Classic write, then read: write adr=BASE+5, dat_w=0xDEADBEEF, sel=1111. Read back adr=BASE+5 → ack one cycle after each stb, dat_r=0xDEADBEEF, 2-cycle spacing.
- Byte lanes: preload 0x11223344, write 0xAABBCCDD with sel=0101 → read returns 0x11BB33DD.
- Wrap4 read burst from adr=BASE+6, cti 010,010,010,111 → ack on 4 consecutive cycles, data from words 6,7,4,5. ack=0 the cycle after the 111 beat.
- Out-of-window: adr=BASE+DEPTH_WORDS → err=1 for one cycle, ack=0, RAM unchanged. Read of BASE+0 immediately after → normal ack.
- Burst abort: linear burst of 8 writes with cyc dropped after beat 3 → only beats 1-3 written, ack=0 the cycle after cyc fell, state IDLE.
- Async reset mid-burst: assert rst between clock edges during beat 2 → ack/err low immediately. After release, a fresh classic read succeeds and no partial write is left from the aborted beat.

Source files
------------

// File: rtl/rv32_wb_pkg.sv
// rv32_wb_pkg: shared Wishbone cycle/burst type constants, responder states and byte-lane helper
package rv32_wb_pkg;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST = 3'b001;
  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_EOB = 3'b111;
  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4 = 2'b01;
  localparam logic [1:0] BTE_WRAP8 = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;
  typedef enum logic [1:0] {IDLE, CLASSIC, BURST} wb_state_t;
  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction
endpackage

// File: rtl/rv32_wb_burst_addr.sv
// rv32_wb_burst_addr: next word address of an incrementing burst, wrapping inside the bte block
module rv32_wb_burst_addr import rv32_wb_pkg::*; (
  input  logic [29:0] adr,
  input  logic [1:0]  bte,
  output logic [29:0] nxt
);
  logic [29:0] inc;
  assign inc = adr + 30'd1;
  always_comb
    nxt = bte == BTE_LINEAR ? inc :
          bte == BTE_WRAP4  ? {adr[29:2], inc[1:0]} :
          bte == BTE_WRAP8  ? {adr[29:3], inc[2:0]} :
                              {adr[29:4], inc[3:0]};
endmodule

// File: rtl/rv32_wb_sram.sv
// rv32_wb_sram: registered-feedback Wishbone B4 responder over a word-addressed on-chip RAM
module rv32_wb_sram import rv32_wb_pkg::*; #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned BASE_WORD = 0,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] bus__adr,
  input  logic [31:0] bus__dat_w,
  output logic [31:0] bus__dat_r,
  input  logic [3:0]  bus__sel,
  input  logic        bus__cyc,
  input  logic        bus__stb,
  output logic        bus__ack,
  input  logic        bus__we,
  input  logic [2:0]  bus__cti,
  input  logic [1:0]  bus__bte,
  output logic        bus__err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  logic [31:0] mem [DEPTH_WORDS];
  wb_state_t state;
  logic [29:0] exp_adr, nxt;
  logic [AW-1:0] idx, nxt_idx;
  logic req, hit, nxt_hit, wr, cont;

  function automatic logic in_win(input logic [29:0] a);
    return {2'b0, a} >= BASE_WORD && {2'b0, a} - BASE_WORD < DEPTH_WORDS;
  endfunction

  function automatic logic [AW-1:0] to_idx(input logic [29:0] a);
    return AW'({2'b0, a} - BASE_WORD);
  endfunction

  rv32_wb_burst_addr u_burst_addr (.adr(bus__adr), .bte(bus__bte), .nxt(nxt));

  assign req = bus__cyc & bus__stb;
  assign hit = in_win(bus__adr);
  assign nxt_hit = in_win(nxt);
  assign idx = to_idx(bus__adr);
  assign nxt_idx = to_idx(nxt);
  assign wr = req & bus__we & bus__ack & hit;
  assign cont = req & bus__cti == CTI_INCR & bus__adr == exp_adr & nxt_hit;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      bus__ack <= 1'b0;
      bus__err <= 1'b0;
      bus__dat_r <= '0;
      exp_adr <= '0;
    end else begin
      bus__ack <= 1'b0;
      bus__err <= 1'b0;
      state <= IDLE;
      if (state == IDLE && req && !bus__err) begin
        if (!hit) begin
          bus__err <= 1'b1;
          bus__dat_r <= '0;
        end else begin
          bus__ack <= 1'b1;
          bus__dat_r <= mem[idx];
          exp_adr <= bus__adr;
          state <= bus__cti inside {CTI_CLASSIC, CTI_CONST, CTI_EOB} ? CLASSIC : BURST;
        end
      end else if (state == BURST && cont) begin
        bus__ack <= 1'b1;
        bus__dat_r <= mem[nxt_idx];
        exp_adr <= nxt;
        state <= BURST;
      end
    end

  always_ff @(posedge clk)
    if (wr) mem[idx] <= (mem[idx] & ~byte_mask(bus__sel)) | (bus__dat_w & byte_mask(bus__sel));
endmodule

// File: tb/tb_rv32_wb_sram.sv
// tb_rv32_wb_sram: directed scenarios for the Wishbone SRAM responder with hand-computed expectations
module tb_rv32_wb_sram;
  import rv32_wb_pkg::*;
  localparam int unsigned DEPTH = 64;
  localparam logic [29:0] BASE = 30'h100;

  logic clk = 1'b0, rst = 1'b1;
  logic [29:0] bus__adr = '0;
  logic [31:0] bus__dat_w = '0, bus__dat_r;
  logic [3:0] bus__sel = '0;
  logic bus__cyc = 1'b0, bus__stb = 1'b0, bus__we = 1'b0, bus__ack, bus__err;
  logic [2:0] bus__cti = '0;
  logic [1:0] bus__bte = '0;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  rv32_wb_sram #(.DEPTH_WORDS(DEPTH), .BASE_WORD(32'h100), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst), .bus__adr(bus__adr), .bus__dat_w(bus__dat_w), .bus__dat_r(bus__dat_r),
    .bus__sel(bus__sel), .bus__cyc(bus__cyc), .bus__stb(bus__stb), .bus__ack(bus__ack),
    .bus__we(bus__we), .bus__cti(bus__cti), .bus__bte(bus__bte), .bus__err(bus__err)
  );

  // classic single transfer, called at a negedge; returns latency to ack/err and whether a response lingered
  task automatic classic(input logic [29:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                         output logic [31:0] rd, output int lat, output logic e, output logic tail);
    bus__adr = a; bus__we = w; bus__dat_w = d; bus__sel = s;
    bus__cti = CTI_CLASSIC; bus__bte = BTE_LINEAR; bus__cyc = 1'b1; bus__stb = 1'b1;
    lat = 0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (bus__ack || bus__err) break;
    end
    rd = bus__dat_r; e = bus__err;
    @(negedge clk);
    tail = bus__ack | bus__err;
    bus__cyc = 1'b0; bus__stb = 1'b0; bus__we = 1'b0;
  endtask

  task automatic poke(input logic [29:0] a, input logic [31:0] d);
    logic [31:0] rd; int lat; logic e, t;
    classic(a, 1'b1, d, 4'hF, rd, lat, e, t);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (bus__ack !== 1'b0) begin failures++; $display("FAIL reset_ack: got %b want 0", bus__ack); end
    checks++; if (bus__err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", bus__err); end
    checks++; if (bus__dat_r !== 32'h0) begin failures++; $display("FAIL reset_dat_r: got %h want 00000000", bus__dat_r); end
    rst = 1'b0;
  endtask

  task automatic test_classic();
    logic [31:0] rd; int lat; logic e, t;
    classic(BASE + 30'd5, 1'b1, 32'hDEADBEEF, 4'hF, rd, lat, e, t);
    checks++; if (lat != 1 || e !== 1'b0) begin failures++; $display("FAIL classic_wr_ack: lat=%0d err=%b want lat=1 err=0", lat, e); end
    checks++; if (t !== 1'b0) begin failures++; $display("FAIL classic_wr_drop: got %b want 0", t); end
    classic(BASE + 30'd5, 1'b0, 32'h0, 4'hF, rd, lat, e, t);
    checks++; if (lat != 1) begin failures++; $display("FAIL classic_rd_lat: got %0d want 1", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL classic_rd_data: got %h want deadbeef", rd); end
    checks++; if (t !== 1'b0) begin failures++; $display("FAIL classic_rd_drop: got %b want 0", t); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; int lat; logic e, t;
    poke(BASE + 30'd9, 32'h11223344);
    classic(BASE + 30'd9, 1'b1, 32'hAABBCCDD, 4'b0101, rd, lat, e, t);
    classic(BASE + 30'd9, 1'b0, 32'h0, 4'b0000, rd, lat, e, t);
    checks++; if (rd !== 32'h11BB33DD) begin failures++; $display("FAIL byte_lanes: got %h want 11bb33dd", rd); end
    classic(BASE + 30'd9, 1'b1, 32'hFFFFFFFF, 4'b0000, rd, lat, e, t);
    checks++; if (lat != 1 || e !== 1'b0) begin failures++; $display("FAIL sel0_ack: lat=%0d err=%b want lat=1 err=0", lat, e); end
    classic(BASE + 30'd9, 1'b0, 32'h0, 4'hF, rd, lat, e, t);
    checks++; if (rd !== 32'h11BB33DD) begin failures++; $display("FAIL sel0_nowrite: got %h want 11bb33dd", rd); end
  endtask

  task automatic test_wrap4();
    int seq[4] = '{6, 7, 4, 5};
    for (int k = 4; k < 8; k++) poke(BASE + 30'(k), 32'hA0000000 | 32'(k));
    bus__adr = BASE + 30'd6; bus__we = 1'b0; bus__cti = CTI_INCR; bus__bte = BTE_WRAP4;
    bus__cyc = 1'b1; bus__stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus__adr = BASE + 30'(seq[i]);
      bus__cti = i == 3 ? CTI_EOB : CTI_INCR;
      checks++; if (bus__ack !== 1'b1 || bus__dat_r !== (32'hA0000000 | 32'(seq[i]))) begin
        failures++; $display("FAIL wrap4_beat%0d: ack=%b data=%h want ack=1 data=%h", i, bus__ack, bus__dat_r, 32'hA0000000 | 32'(seq[i]));
      end
    end
    @(negedge clk);
    checks++; if (bus__ack !== 1'b0) begin failures++; $display("FAIL wrap4_end: ack=%b want 0", bus__ack); end
    bus__cyc = 1'b0; bus__stb = 1'b0;
  endtask

  task automatic test_window_edge();
    poke(BASE + 30'd62, 32'h0000003E);
    poke(BASE + 30'd63, 32'h0000003F);
    bus__adr = BASE + 30'd62; bus__we = 1'b0; bus__cti = CTI_INCR; bus__bte = BTE_LINEAR;
    bus__cyc = 1'b1; bus__stb = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus__adr = BASE + 30'(62 + i);
      checks++; if (bus__ack !== 1'b1 || bus__dat_r !== 32'(62 + i)) begin
        failures++; $display("FAIL edge_beat%0d: ack=%b data=%h want ack=1 data=%h", i, bus__ack, bus__dat_r, 32'(62 + i));
      end
    end
    @(negedge clk);
    bus__adr = BASE + 30'd64;
    checks++; if (bus__ack !== 1'b0 || bus__err !== 1'b0) begin failures++; $display("FAIL edge_stop: ack=%b err=%b want 0 0", bus__ack, bus__err); end
    @(negedge clk);
    checks++; if (bus__err !== 1'b1 || bus__ack !== 1'b0) begin failures++; $display("FAIL edge_reerr: ack=%b err=%b want 0 1", bus__ack, bus__err); end
    @(negedge clk);
    checks++; if (bus__err !== 1'b0) begin failures++; $display("FAIL edge_err_len: err=%b want 0", bus__err); end
    bus__cyc = 1'b0; bus__stb = 1'b0;
  endtask

  task automatic test_out_of_window();
    logic [31:0] rd; int lat; logic e, t;
    poke(BASE, 32'h01234567);
    classic(BASE + 30'(DEPTH), 1'b1, 32'hFFFFFFFF, 4'hF, rd, lat, e, t);
    checks++; if (lat != 1 || e !== 1'b1) begin failures++; $display("FAIL oow_err: lat=%0d err=%b want lat=1 err=1", lat, e); end
    checks++; if (t !== 1'b0) begin failures++; $display("FAIL oow_err_len: got %b want 0", t); end
    classic(BASE, 1'b0, 32'h0, 4'hF, rd, lat, e, t);
    checks++; if (lat != 1 || e !== 1'b0 || rd !== 32'h01234567) begin
      failures++; $display("FAIL oow_unchanged: lat=%0d err=%b data=%h want lat=1 err=0 data=01234567", lat, e, rd);
    end
    classic(BASE - 30'd1, 1'b0, 32'h0, 4'hF, rd, lat, e, t);
    checks++; if (e !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL below_err: err=%b data=%h want err=1 data=00000000", e, rd); end
  endtask

  task automatic test_burst_abort();
    logic [31:0] rd; int lat; logic e, t;
    for (int k = 0; k < 5; k++) poke(BASE + 30'(16 + k), 32'h55555555);
    bus__adr = BASE + 30'd16; bus__dat_w = 32'hB0000000; bus__sel = 4'hF; bus__we = 1'b1;
    bus__cti = CTI_INCR; bus__bte = BTE_LINEAR; bus__cyc = 1'b1; bus__stb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus__adr = BASE + 30'(16 + i); bus__dat_w = 32'hB0000000 | 32'(i);
      checks++; if (bus__ack !== 1'b1) begin failures++; $display("FAIL abort_beat%0d: ack=%b want 1", i, bus__ack); end
    end
    @(negedge clk);
    bus__cyc = 1'b0; bus__stb = 1'b0; bus__we = 1'b0;
    @(negedge clk);
    checks++; if (bus__ack !== 1'b0 || bus__err !== 1'b0) begin failures++; $display("FAIL abort_drop: ack=%b err=%b want 0 0", bus__ack, bus__err); end
    for (int k = 0; k < 5; k++) begin
      classic(BASE + 30'(16 + k), 1'b0, 32'h0, 4'hF, rd, lat, e, t);
      checks++; if (rd !== (k < 3 ? 32'hB0000000 | 32'(k) : 32'h55555555)) begin
        failures++; $display("FAIL abort_word%0d: got %h want %h", k, rd, k < 3 ? 32'hB0000000 | 32'(k) : 32'h55555555);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] rd; int lat; logic e, t;
    poke(BASE + 30'd32, 32'h66666666);
    poke(BASE + 30'd33, 32'h77777777);
    bus__adr = BASE + 30'd32; bus__dat_w = 32'hC0000000; bus__sel = 4'hF; bus__we = 1'b1;
    bus__cti = CTI_INCR; bus__bte = BTE_LINEAR; bus__cyc = 1'b1; bus__stb = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus__adr = BASE + 30'd33; bus__dat_w = 32'hC0000001;
    checks++; if (bus__ack !== 1'b1) begin failures++; $display("FAIL arst_beat2: ack=%b want 1", bus__ack); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus__ack !== 1'b0 || bus__err !== 1'b0) begin failures++; $display("FAIL arst_immediate: ack=%b err=%b want 0 0", bus__ack, bus__err); end
    @(negedge clk);
    bus__cyc = 1'b0; bus__stb = 1'b0; bus__we = 1'b0; rst = 1'b0;
    classic(BASE + 30'd33, 1'b0, 32'h0, 4'hF, rd, lat, e, t);
    checks++; if (lat != 1 || rd !== 32'h77777777) begin failures++; $display("FAIL arst_no_partial: lat=%0d data=%h want lat=1 data=77777777", lat, rd); end
    classic(BASE + 30'd32, 1'b0, 32'h0, 4'hF, rd, lat, e, t);
    checks++; if (rd !== 32'hC0000000) begin failures++; $display("FAIL arst_beat1_kept: got %h want c0000000", rd); end
  endtask

  initial begin
    test_reset();
    test_classic();
    test_byte_lanes();
    test_wrap4();
    test_window_edge();
    test_out_of_window();
    test_burst_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
